mask_deserializer: RTL

- Downstream consumer of the mask serializer stage.
- Drives the serializer's `next` strobe and collects one OP_CHANNEL_WIDTH-bit slice per shift.
- Re-assembles the full IP_CHANNEL_WIDTH-bit mask row in the serializer's interleaved bit order.
- Presents the row to the next stage over a valid/ready handshake, with back-pressure.

---
 rtl/mask_deserializer_pkg.sv | 32 +++
 rtl/mask_deserializer_if.sv | 23 ++
 rtl/mask_deserializer_slice_scatter.sv | 26 ++
 rtl/mask_deserializer.sv | 120 ++++++++++++
 4 files changed

// File: rtl/mask_deserializer_pkg.sv
// Shared widths, per-resolution slice counts and state/resolution encodings
// for the mask deserializer and its scatter network.
package mask_pkg;

    localparam int IP_CHANNEL_WIDTH = 1080;
    localparam int OP_CHANNEL_WIDTH = 20;
    localparam int stepSel0         = 16;
    localparam int stepSel1         = 32;
    localparam int stepSel2         = 54;

    typedef enum logic [1:0] {
        RES_320  = 2'b00,
        RES_640  = 2'b01,
        RES_1080 = 2'b10
    } res_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        FULL    = 2'd2
    } state_e;

    // Only meaningful for legal resolutions; 2'b11 is rejected before use.
    function automatic logic [5:0] step_of(input logic [1:0] res);
        case (res)
            RES_320: return 6'(stepSel0);
            RES_640: return 6'(stepSel1);
            default: return 6'(stepSel2);
        endcase
    endfunction

endpackage

// File: rtl/mask_deserializer_if.sv
// Serializer-side slice link plus downstream row handshake.
// slave = deserializer view, master = serializer/consumer view.
interface mask_deserializer_if;
    import mask_pkg::*;

    logic [OP_CHANNEL_WIDTH-1:0] ser_dout;
    logic                        ser_done;
    logic                        ser_next;
    logic [IP_CHANNEL_WIDTH-1:0] row_data;
    logic                        row_valid;
    logic                        row_ready;

    modport slave (
        input  ser_dout, ser_done, row_ready,
        output ser_next, row_data, row_valid
    );

    modport master (
        output ser_dout, ser_done, row_ready,
        input  ser_next, row_data, row_valid
    );

endinterface

// File: rtl/mask_deserializer_slice_scatter.sv
// Combinational placement of slice k: bit i lands at row position i*step+k.
// Produces a per-bit write enable and the data to write there.
module mask_slice_scatter
    import mask_pkg::*;
(
    input  logic [OP_CHANNEL_WIDTH-1:0] slice_i,
    input  logic [5:0]                  k_i,
    input  logic [5:0]                  step_i,
    output logic [IP_CHANNEL_WIDTH-1:0] wen_o,
    output logic [IP_CHANNEL_WIDTH-1:0] wdat_o
);

    always_comb begin
        wen_o  = '0;
        wdat_o = '0;
        for (int i = 0; i < OP_CHANNEL_WIDTH; i++) begin
            logic [10:0] pos;
            pos = 11'(i) * {5'd0, step_i} + {5'd0, k_i};
            if (pos < 11'(IP_CHANNEL_WIDTH)) begin
                wen_o[pos]  = 1'b1;
                wdat_o[pos] = slice_i[i];
            end
        end
    end

endmodule

// File: rtl/mask_deserializer.sv
// Pulls step_r slices from the serializer and rebuilds the interleaved mask row; row_valid step_r+1 cycles after start.
// Back-pressure: a full row is held with ser_next low until row_ready, so the serializer keeps its data.
module mask_deserializer
    import mask_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            imageResolution,
    input  logic                  abort,
    output logic                  res_err,
    mask_deserializer_if.slave    bus
);

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_CAPTURE = CAPTURE;
    localparam logic [1:0] ST_FULL    = FULL;

    logic [1:0]                  state_q, state_d;
    logic [5:0]                  k_q, k_d;
    logic [5:0]                  step_q, step_d;
    logic [IP_CHANNEL_WIDTH-1:0] row_q, row_d;
    logic                        next_q, next_d;
    logic                        valid_q, valid_d;
    logic                        err_q, err_d;
    logic                        bad_q, bad_d;

    logic [IP_CHANNEL_WIDTH-1:0] wen;
    logic [IP_CHANNEL_WIDTH-1:0] wdat;

    mask_slice_scatter u_scatter (
        .slice_i (bus.ser_dout),
        .k_i     (k_q),
        .step_i  (step_q),
        .wen_o   (wen),
        .wdat_o  (wdat)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        step_d  = step_q;
        row_d   = row_q;
        next_d  = next_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        bad_d   = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            next_d  = 1'b0;
            valid_d = 1'b0;
            k_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!bus.ser_done) begin
                        if (imageResolution != 2'b11) begin
                            step_d  = step_of(imageResolution);
                            row_d   = '0;
                            k_d     = '0;
                            next_d  = 1'b1;
                            state_d = ST_CAPTURE;
                        end else begin
                            // One pulse per continuous illegal request, not one per cycle.
                            bad_d = 1'b1;
                            err_d = !bad_q;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (next_q) begin
                        row_d = (row_q & ~wen) | (wdat & wen);
                        if (k_q == step_q - 6'd1) begin
                            k_d     = '0;
                            next_d  = 1'b0;
                            valid_d = 1'b1;
                            state_d = ST_FULL;
                        end else begin
                            k_d = k_q + 6'd1;
                        end
                    end
                end
                ST_FULL: begin
                    if (bus.row_ready) begin
                        valid_d = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            step_q  <= '0;
            row_q   <= '0;
            next_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            step_q  <= step_d;
            row_q   <= row_d;
            next_q  <= next_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            bad_q   <= bad_d;
        end
    end

    assign bus.ser_next  = next_q;
    assign bus.row_data  = row_q;
    assign bus.row_valid = valid_q;
    assign res_err       = err_q;

endmodule
